// File: rtl/cpu_sequencer_if.sv
// Instruction/data memory handshake bundle for cpu_sequencer.
// The sequencer raises requests; memories answer with single-cycle acks.
interface cpu_sequencer_if;
  logic imem_req_po;
  logic imem_ack_pi;
  logic dmem_req_po;
  logic dmem_we_po;
  logic dmem_ack_pi;

  modport master (
    output imem_req_po,
    output dmem_req_po,
    output dmem_we_po,
    input  imem_ack_pi,
    input  dmem_ack_pi
  );

  modport slave (
    input  imem_req_po,
    input  dmem_req_po,
    input  dmem_we_po,
    output imem_ack_pi,
    output dmem_ack_pi
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM for the 16-bit processor.
// Owns PC and carry/borrow flags; steps each instruction FETCH..WB.
module cpu_sequencer #(
  parameter int PC_WIDTH = 16
) (
  input  logic                clk_pi,
  input  logic                rst_n_pi,
  cpu_sequencer_if.master     mem,
  input  logic                alu_class_pi,
  input  logic                arith_2op_pi,
  input  logic [2:0]          alu_func_pi,
  input  logic                load_pi,
  input  logic                store_pi,
  input  logic                branch_eq_pi,
  input  logic                branch_ge_pi,
  input  logic                branch_le_pi,
  input  logic                branch_carry_pi,
  input  logic                jump_pi,
  input  logic                stc_pi,
  input  logic                stb_pi,
  input  logic                halt_pi,
  input  logic                rst_cmd_pi,
  input  logic [11:0]         immediate_pi,
  input  logic                cmp_eq_pi,
  input  logic                cmp_lt_pi,
  input  logic                alu_carry_pi,
  output logic [PC_WIDTH-1:0] pc_po,
  output logic                ir_load_po,
  output logic                reg_we_po,
  output logic                wb_sel_po,
  output logic                carry_po,
  output logic                borrow_po,
  output logic                halted_po,
  output logic [2:0]          state_po
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;

  state_t              state, state_n;
  logic [PC_WIDTH-1:0] pc, pc_n;
  logic                carry, carry_n;
  logic                borrow, borrow_n;

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] br_off;
  logic [PC_WIDTH-1:0] pc_br;
  logic [PC_WIDTH-1:0] jmp_tgt;
  logic                is_branch;
  logic                taken;

  assign pc_inc  = pc + PC_WIDTH'(1);
  assign br_off  = {{(PC_WIDTH-6){immediate_pi[5]}}, immediate_pi[5:0]};
  assign pc_br   = pc_inc + br_off;
  assign jmp_tgt = PC_WIDTH'(immediate_pi);

  assign is_branch = branch_eq_pi | branch_ge_pi
                   | branch_le_pi | branch_carry_pi;

  assign taken = (branch_eq_pi    & cmp_eq_pi)
               | (branch_ge_pi    & ~cmp_lt_pi)
               | (branch_le_pi    & (cmp_lt_pi | cmp_eq_pi))
               | (branch_carry_pi & carry);

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      state  <= IDLE;
      pc     <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      carry  <= carry_n;
      borrow <= borrow_n;
    end
  end

  always_comb begin
    state_n         = state;
    pc_n            = pc;
    carry_n         = carry;
    borrow_n        = borrow;
    mem.imem_req_po = 1'b0;
    mem.dmem_req_po = 1'b0;
    mem.dmem_we_po  = 1'b0;
    ir_load_po      = 1'b0;
    reg_we_po       = 1'b0;
    wb_sel_po       = 1'b0;
    unique case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        mem.imem_req_po = 1'b1;
        if (mem.imem_ack_pi) begin
          ir_load_po = 1'b1;
          state_n    = DECODE;
        end
      end
      DECODE: state_n = EXEC;
      EXEC: begin
        // One action per instruction, highest priority first.
        if (halt_pi) begin
          state_n = HALT;
        end else if (rst_cmd_pi) begin
          pc_n     = '0;
          carry_n  = 1'b0;
          borrow_n = 1'b0;
          state_n  = FETCH;
        end else if (stc_pi | stb_pi) begin
          carry_n  = carry | stc_pi;
          borrow_n = borrow | stb_pi;
          pc_n     = pc_inc;
          state_n  = FETCH;
        end else if (is_branch) begin
          pc_n    = taken ? pc_br : pc_inc;
          state_n = FETCH;
        end else if (jump_pi) begin
          pc_n    = jmp_tgt;
          state_n = FETCH;
        end else if (load_pi | store_pi) begin
          state_n = MEM;
        end else if (alu_class_pi) begin
          state_n = WB;
          if (arith_2op_pi && alu_func_pi[2:1] == 2'b00)
            carry_n = alu_carry_pi;
          if (arith_2op_pi && alu_func_pi[2:1] == 2'b01)
            borrow_n = alu_carry_pi;
        end else begin
          pc_n    = pc_inc;
          state_n = FETCH;
        end
      end
      MEM: begin
        mem.dmem_req_po = 1'b1;
        mem.dmem_we_po  = store_pi;
        if (mem.dmem_ack_pi) begin
          if (store_pi) begin
            pc_n    = pc_inc;
            state_n = FETCH;
          end else begin
            state_n = WB;
          end
        end
      end
      WB: begin
        reg_we_po = 1'b1;
        wb_sel_po = load_pi;
        pc_n      = pc_inc;
        state_n   = FETCH;
      end
      HALT: state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

  assign pc_po     = pc;
  assign carry_po  = carry;
  assign borrow_po = borrow;
  assign halted_po = (state == HALT);
  assign state_po  = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed plan steps plus random
// instruction stream against an instruction-level reference model.
module tb_cpu_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  typedef struct packed {
    bit        alu;
    bit        a2;
    bit        ld;
    bit        st;
    bit        beq;
    bit        bge;
    bit        ble;
    bit        bc;
    bit        jmp;
    bit        stc;
    bit        stb;
    bit        hlt;
    bit        rcmd;
    bit        eq;
    bit        lt;
    bit        cy;
    bit [2:0]  fn;
    bit [11:0] imm;
  } instr_t;

  instr_t cur;

  cpu_sequencer_if mem_if();

  logic [15:0] pc_po;
  logic        ir_load_po;
  logic        reg_we_po;
  logic        wb_sel_po;
  logic        carry_po;
  logic        borrow_po;
  logic        halted_po;
  logic [2:0]  state_po;

  cpu_sequencer #(.PC_WIDTH(16)) dut (
    .clk_pi          (clk),
    .rst_n_pi        (rst_n),
    .mem             (mem_if),
    .alu_class_pi    (cur.alu),
    .arith_2op_pi    (cur.a2),
    .alu_func_pi     (cur.fn),
    .load_pi         (cur.ld),
    .store_pi        (cur.st),
    .branch_eq_pi    (cur.beq),
    .branch_ge_pi    (cur.bge),
    .branch_le_pi    (cur.ble),
    .branch_carry_pi (cur.bc),
    .jump_pi         (cur.jmp),
    .stc_pi          (cur.stc),
    .stb_pi          (cur.stb),
    .halt_pi         (cur.hlt),
    .rst_cmd_pi      (cur.rcmd),
    .immediate_pi    (cur.imm),
    .cmp_eq_pi       (cur.eq),
    .cmp_lt_pi       (cur.lt),
    .alu_carry_pi    (cur.cy),
    .pc_po           (pc_po),
    .ir_load_po      (ir_load_po),
    .reg_we_po       (reg_we_po),
    .wb_sel_po       (wb_sel_po),
    .carry_po        (carry_po),
    .borrow_po       (borrow_po),
    .halted_po       (halted_po),
    .state_po        (state_po)
  );

  int checks   = 0;
  int failures = 0;
  int m_pc     = 0;
  bit m_c      = 1'b0;
  bit m_b      = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cur = '0;
    mem_if.imem_ack_pi = 1'b0;
    mem_if.dmem_ack_pi = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", state_po, 0);
    chk("rst_pc", pc_po, 0);
    chk("rst_flags", {carry_po, borrow_po}, 0);
    chk("rst_outs", {mem_if.imem_req_po, mem_if.dmem_req_po,
        mem_if.dmem_we_po, ir_load_po, reg_we_po, wb_sel_po,
        halted_po}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_to_fetch", state_po, 1);
    m_pc = 0;
    m_c  = 1'b0;
    m_b  = 1'b0;
  endtask

  // Runs one instruction starting at a negedge in FETCH and
  // compares every observable against the instruction-level model.
  task automatic run(input instr_t in, input int idl, input int ddl);
    int     cyc = 0, iw = 0, dw = 0, we_cnt = 0, dreq_cnt = 0;
    bit     left = 0, pc_ok = 1, dwe_ok = 1, sel = 0, fin = 0;
    longint tr = 0, etr = 0;
    int     pc0 = m_pc;
    int     ecyc, off, edreq = 0;
    bit     ewe = 0, esel = 0, ehalt = 0, taken;
    logic [2:0] s;
    cur = in;
    for (int k = 0; k < 64; k++) begin
      s = state_po;
      if ((left && s == 3'd1) || s == 3'd6) begin
        fin = 1;
        break;
      end
      if (s != 3'd1) left = 1;
      if (s == 3'd1 && pc_po !== pc0[15:0]) pc_ok = 0;
      tr = (tr << 3) | longint'(s);
      if (mem_if.imem_req_po) begin
        mem_if.imem_ack_pi = (iw == idl);
        iw++;
      end else begin
        mem_if.imem_ack_pi = 1'($urandom % 2);
      end
      if (mem_if.dmem_req_po) begin
        dreq_cnt++;
        if (mem_if.dmem_we_po !== in.st) dwe_ok = 0;
        mem_if.dmem_ack_pi = (dw == ddl);
        dw++;
      end else begin
        mem_if.dmem_ack_pi = 1'($urandom % 2);
      end
      if (reg_we_po) begin
        we_cnt++;
        sel = wb_sel_po;
      end
      cyc++;
      @(negedge clk);
    end
    chk("bounded", fin, 1);

    for (int j = 0; j <= idl; j++) etr = (etr << 3) | 1;
    etr  = (etr << 3) | 2;
    etr  = (etr << 3) | 3;
    ecyc = idl + 3;
    off  = in.imm[5] ? int'(in.imm[5:0]) - 64 : int'(in.imm[5:0]);
    taken = (in.beq && in.eq) || (in.bge && !in.lt)
         || (in.ble && (in.lt || in.eq)) || (in.bc && m_c);
    if (in.hlt) begin
      ehalt = 1;
    end else if (in.rcmd) begin
      m_pc = 0; m_c = 0; m_b = 0;
    end else if (in.stc || in.stb) begin
      m_c = m_c | in.stc;
      m_b = m_b | in.stb;
      m_pc = (m_pc + 1) & 16'hFFFF;
    end else if (in.beq || in.bge || in.ble || in.bc) begin
      m_pc = (m_pc + 1 + (taken ? off : 0)) & 16'hFFFF;
    end else if (in.jmp) begin
      m_pc = int'(in.imm);
    end else if (in.ld || in.st) begin
      for (int j = 0; j <= ddl; j++) etr = (etr << 3) | 4;
      edreq = ddl + 1;
      ecyc += ddl + 1;
      if (in.ld) begin
        etr = (etr << 3) | 5;
        ecyc += 1;
        ewe = 1;
        esel = 1;
      end
      m_pc = (m_pc + 1) & 16'hFFFF;
    end else if (in.alu) begin
      etr = (etr << 3) | 5;
      ecyc += 1;
      ewe = 1;
      if (in.a2 && in.fn < 2) m_c = in.cy;
      else if (in.a2 && in.fn < 4) m_b = in.cy;
      m_pc = (m_pc + 1) & 16'hFFFF;
    end else begin
      m_pc = (m_pc + 1) & 16'hFFFF;
    end

    chk("cycles", cyc, ecyc);
    chk("state_trace", tr, etr);
    chk("pc", pc_po, m_pc[15:0]);
    chk("carry", carry_po, m_c);
    chk("borrow", borrow_po, m_b);
    chk("halted", halted_po, ehalt);
    chk("reg_we_count", we_cnt, ewe ? 1 : 0);
    if (ewe) chk("wb_sel", sel, esel);
    chk("dmem_req_cycles", dreq_cnt, edreq);
    chk("dmem_we", dwe_ok, 1);
    chk("pc_stable_fetch", pc_ok, 1);
  endtask

  initial begin
    instr_t i;
    int     r;
    bit     hit;
    logic [15:0] pc_h;

    rst_n = 1'b1;
    cur = '0;
    mem_if.imem_ack_pi = 1'b0;
    mem_if.dmem_ack_pi = 1'b0;
    #1;
    do_reset();

    for (int n = 0; n < 3; n++) run('0, 0, 0);
    chk("nop_pc3", pc_po, 16'd3);

    i = '0; i.alu = 1; i.a2 = 1; i.fn = 3'b000; i.cy = 1;
    run(i, 2, 0);
    chk("alu_carry_set", carry_po, 1);

    i = '0; i.ld = 1;
    run(i, 0, 3);
    i = '0; i.st = 1;
    run(i, 0, 3);

    i = '0; i.jmp = 1; i.imm = 12'd5;
    run(i, 0, 0);
    i = '0; i.beq = 1; i.eq = 1; i.imm = 12'h03E;
    run(i, 0, 0);
    chk("beq_taken_pc4", pc_po, 16'd4);
    i = '0; i.jmp = 1; i.imm = 12'd5;
    run(i, 0, 0);
    i = '0; i.beq = 1; i.eq = 0; i.imm = 12'h03E;
    run(i, 0, 0);
    chk("beq_not_taken_pc6", pc_po, 16'd6);

    i = '0; i.stc = 1;
    run(i, 1, 0);
    i = '0; i.jmp = 1; i.imm = 12'd0;
    run(i, 0, 0);
    i = '0; i.beq = 1; i.eq = 1; i.imm = 12'h03E;
    run(i, 0, 0);
    chk("wrap_back_ffff", pc_po, 16'hFFFF);
    i = '0; i.bc = 1; i.imm = 12'd1;
    run(i, 0, 0);
    chk("bc_wrap_pc1", pc_po, 16'd1);

    i = '0; i.jmp = 1; i.imm = 12'h0A0;
    run(i, 0, 0);
    chk("jump_a0", pc_po, 16'h00A0);
    i = '0; i.rcmd = 1; i.stc = 1;
    run(i, 0, 0);
    chk("rst_cmd_pc", pc_po, 0);
    chk("rst_cmd_carry", carry_po, 0);

    for (int n = 0; n < 150; n++) begin
      i = '0;
      i.alu  = ($urandom % 3) == 0;
      i.a2   = 1'($urandom % 2);
      i.fn   = 3'($urandom);
      r      = int'($urandom % 6);
      i.ld   = (r == 0);
      i.st   = (r == 1);
      i.beq  = ($urandom % 10) == 0;
      i.bge  = ($urandom % 10) == 0;
      i.ble  = ($urandom % 10) == 0;
      i.bc   = ($urandom % 10) == 0;
      i.jmp  = ($urandom % 10) == 0;
      i.stc  = ($urandom % 12) == 0;
      i.stb  = ($urandom % 12) == 0;
      i.rcmd = ($urandom % 30) == 0;
      i.eq   = 1'($urandom % 2);
      i.lt   = 1'($urandom % 2);
      i.cy   = 1'($urandom % 2);
      i.imm  = 12'($urandom);
      run(i, int'($urandom % 3), int'($urandom % 4));
    end

    i = '0; i.hlt = 1; i.jmp = 1; i.imm = 12'h123;
    run(i, 0, 0);
    pc_h = pc_po;
    for (int k = 0; k < 10; k++) begin
      mem_if.imem_ack_pi = 1'(k % 2);
      mem_if.dmem_ack_pi = 1'(k % 2);
      @(negedge clk);
      chk("halt_hold", {halted_po, state_po, pc_po,
          mem_if.imem_req_po, mem_if.dmem_req_po, reg_we_po},
          {1'b1, 3'd6, pc_h, 3'b000});
    end

    do_reset();
    i = '0; i.ld = 1;
    cur = i;
    mem_if.imem_ack_pi = 1'b1;
    mem_if.dmem_ack_pi = 1'b0;
    hit = 0;
    for (int k = 0; k < 10; k++) begin
      if (state_po == 3'd4) begin
        hit = 1;
        break;
      end
      @(negedge clk);
    end
    chk("reached_mem", hit, 1);
    chk("mem_req_up", mem_if.dmem_req_po, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_drop_req", {mem_if.dmem_req_po, mem_if.dmem_we_po,
        reg_we_po, mem_if.imem_req_po}, 0);
    chk("async_idle", state_po, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_fetch", state_po, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
